// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational 16-bit ALU: buffers commands in a small FIFO,
// drives the ALU for a settle window, then presents result/NZCV over valid/ready.
module alu_issue_stage #(
    parameter int unsigned CMD_DEPTH = 2,
    parameter int unsigned SETTLE    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_sub,
    input  logic [15:0] alu_result,
    input  logic [3:0]  alu_cc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_cc,
    output logic        rsp_err,
    output logic [3:0]  last_cc,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam int unsigned AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    state_e         state;
    logic [CW-1:0]  settle_cnt;

    logic [35:0]    mem [CMD_DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [35:0]    head;
    logic [3:0]     head_op;
    logic           head_legal;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0011, 4'b0100, 4'b1010: is_legal = 1'b0;
            default:                            is_legal = 1'b1;
        endcase
    endfunction

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && !full;
    assign pop        = !empty && ((state == StIdle) || ((state == StResp) && rsp_ready));
    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_op    = head[35:32];
    assign head_legal = is_legal(head_op);
    assign busy       = (state != StIdle) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            settle_cnt <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sub    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_cc     <= '0;
            rsp_err    <= 1'b0;
            last_cc    <= '0;
            err_count  <= '0;
        end else begin
            unique case (state)
                StIdle: ;
                StDrive: begin
                    if (settle_cnt == CW'(1)) begin
                        rsp_result <= alu_result;
                        rsp_cc     <= alu_cc;
                        rsp_err    <= 1'b0;
                        last_cc    <= alu_cc;
                        rsp_valid  <= 1'b1;
                        state      <= StResp;
                    end else begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (!pop) state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            // Pop overrides the RESP release above so back-to-back illegal ops keep valid high.
            if (pop) begin
                if (head_legal) begin
                    alu_op     <= head_op;
                    alu_a      <= head[31:16];
                    alu_b      <= head[15:0];
                    alu_sub    <= (head_op == 4'b0010);
                    settle_cnt <= CW'(SETTLE);
                    state      <= StDrive;
                end else begin
                    rsp_result <= '0;
                    rsp_cc     <= '0;
                    rsp_err    <= 1'b1;
                    rsp_valid  <= 1'b1;
                    if (err_count != 8'hff) err_count <= err_count + 8'd1;
                    state      <= StResp;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU on the alu_* ports and an in-order
// scoreboard of commands checked against each accepted response.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_sub;
    logic [15:0] alu_result;
    logic [3:0]  alu_cc;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_cc;
    logic        rsp_err;
    logic [3:0]  last_cc;
    logic [7:0]  err_count;
    logic        busy;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    cmd_t        sb [$];
    cmd_t        mc;
    cmd_t        mp;
    cmd_t        exp_alu;
    logic [3:0]  exp_last_cc;
    logic [7:0]  exp_err_cnt;
    logic [3:0]  ecc;
    logic [15:0] eres;
    logic [15:0] last_rsp;
    logic [3:0]  ill [4] = '{4'h0, 4'h3, 4'h4, 4'hA};
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sub    (alu_sub),
        .alu_result (alu_result),
        .alu_cc     (alu_cc),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cc     (rsp_cc),
        .rsp_err    (rsp_err),
        .last_cc    (last_cc),
        .err_count  (err_count),
        .busy       (busy)
    );

    // Returns {N,Z,C,V, result}; add/sub share one adder selected by sub.
    function automatic logic [19:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic sub);
        logic [16:0] s;
        logic [15:0] r;
        logic [31:0] m;
        logic        c;
        logic        v;
        s = '0; r = '0; m = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0001, 4'b0010: begin
                if (sub) begin
                    s = {1'b0, a} - {1'b0, b};
                    r = s[15:0];
                    c = ~s[16];
                    v = (a[15] != b[15]) && (r[15] != a[15]);
                end else begin
                    s = {1'b0, a} + {1'b0, b};
                    r = s[15:0];
                    c = s[16];
                    v = (a[15] == b[15]) && (r[15] != a[15]);
                end
            end
            4'b0101: r = a << b[3:0];
            4'b0110: r = $signed(a) >>> b[3:0];
            4'b0111: r = a >> b[3:0];
            4'b1000: r = (a << b[3:0]) | (a >> (5'd16 - {1'b0, b[3:0]}));
            4'b1001: r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
            4'b1011: r = a & b;
            4'b1100: r = a | b;
            4'b1101: r = a ^ b;
            4'b1110: r = ~a;
            4'b1111: begin m = a * b; r = m[15:0]; end
            default: r = '0;
        endcase
        return {r[15], (r == 16'h0), c, v, r};
    endfunction

    function automatic logic legal(input logic [3:0] op);
        return !(op inside {4'h0, 4'h3, 4'h4, 4'hA});
    endfunction

    assign {alu_cc, alu_result} = alu_model(alu_op, alu_a, alu_b, alu_sub);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mc = sb.pop_front();
                    if (legal(mc.op)) begin
                        {ecc, eres} = alu_model(mc.op, mc.a, mc.b, mc.op == 4'b0010);
                        exp_last_cc = ecc;
                        exp_alu     = mc;
                    end else begin
                        ecc  = '0;
                        eres = '0;
                        if (exp_err_cnt != 8'hff) exp_err_cnt = exp_err_cnt + 8'd1;
                    end
                    check_eq("rsp_result", rsp_result, eres);
                    check_eq("rsp_cc", rsp_cc, ecc);
                    check_eq("rsp_err", rsp_err, !legal(mc.op));
                    check_eq("last_cc", last_cc, exp_last_cc);
                    check_eq("err_count", err_count, exp_err_cnt);
                    check_eq("alu_op", alu_op, exp_alu.op);
                    check_eq("alu_sub", alu_sub, exp_alu.op == 4'b0010);
                    check_eq("alu_ab", {alu_a, alu_b}, {exp_alu.a, exp_alu.b});
                    last_rsp = rsp_result;
                end
            end
            if (cmd_valid && cmd_ready) begin
                mp.op = cmd_op;
                mp.a  = cmd_a;
                mp.b  = cmd_b;
                sb.push_back(mp);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        while (!cmd_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        check_eq("send_accept", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 100) begin
            t++;
            @(negedge clk);
        end
        check_eq(tag, rsp_valid, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && t < 2000) begin
            t++;
            @(negedge clk);
        end
        check_eq(tag, (sb.size() == 0) && !busy, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        sb.delete();
        exp_alu     = '0;
        exp_last_cc = '0;
        exp_err_cnt = '0;
        last_rsp    = '0;
    endtask

    initial begin
        int stale;
        clear_model();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_ctl", {alu_op, alu_sub, rsp_valid, rsp_err, rsp_cc, last_cc, err_count}, 0);
        check_eq("rst_ab", {alu_a, alu_b}, 0);
        check_eq("rst_result", rsp_result, 0);
        check_eq("rst_ready_busy", {cmd_ready, busy}, 2'b10);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ADD: latency and captured result
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 4'b0001; cmd_a = 16'd10000; cmd_b = 16'd15000;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check_eq("lat_e0_valid", rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        check_eq("lat_e1_valid", rsp_valid, 1'b0);
        check_eq("add_drive", {alu_op, alu_sub, alu_a, alu_b}, {4'b0001, 1'b0, 16'd10000, 16'd15000});
        @(posedge clk);
        #1;
        check_eq("lat_e2_valid", rsp_valid, 1'b1);
        check_eq("add_result", {rsp_err, rsp_cc, rsp_result}, {1'b0, 4'b0000, 16'd25000});
        check_eq("add_last_cc", last_cc, 4'b0000);
        wait_drain("drain_add");

        // Back-to-back ADD overflow then SUB
        send(4'b0001, 16'd32767, 16'd1);
        send(4'b0010, 16'd15000, 16'd5000);
        wait_rsp("b2b_first_timeout");
        check_eq("b2b_first", {rsp_cc, rsp_result}, {4'b1001, 16'h8000});
        wait_drain("drain_b2b");
        check_eq("b2b_second", last_rsp, 16'd10000);
        check_eq("b2b_last_cc", last_cc, 4'b0010);

        // Backpressure: one in RESP plus a full FIFO
        rsp_ready = 1'b0;
        send(4'b0001, 16'd1, 16'd2);
        send(4'b0001, 16'd3, 16'd4);
        send(4'b1101, 16'hf0f0, 16'h0ff0);
        cmd_valid = 1'b1; cmd_op = 4'b1011; cmd_a = 16'h1234; cmd_b = 16'h5678;
        repeat (4) @(negedge clk);
        check_eq("bp_cmd_ready", cmd_ready, 1'b0);
        check_eq("bp_hold_rsp", {rsp_valid, rsp_result}, {1'b1, 16'd3});
        check_eq("bp_hold_alu", {alu_a, alu_b}, {16'd1, 16'd2});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain("drain_bp");
        check_eq("bp_last", last_rsp, 16'hff00);

        // Illegal op between two MULs
        send(4'b1111, 16'd100, 16'd200);
        send(4'b1010, 16'hdead, 16'hbeef);
        send(4'b1111, 16'd54321, 16'd0);
        wait_drain("drain_ill");
        check_eq("ill_err_count", err_count, 8'd1);
        check_eq("ill_alu_op", alu_op, 4'b1111);
        check_eq("ill_last_cc", last_cc, 4'b0100);
        check_eq("ill_last_rsp", last_rsp, 16'd0);

        // Saturating illegal-op counter
        for (int i = 0; i < 256; i++) begin
            send(ill[i % 4], i[15:0], ~i[15:0]);
        end
        wait_drain("drain_sat");
        check_eq("sat_err_count", err_count, 8'hff);
        check_eq("sat_last_cc", last_cc, 4'b0100);

        // Reset while in DRIVE with a command queued
        send(4'b0001, 16'd1, 16'd1);
        send(4'b0001, 16'd2, 16'd2);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ctl", {alu_op, alu_sub, rsp_valid, rsp_err, rsp_cc, last_cc, err_count}, 0);
        check_eq("mid_rst_ab", {alu_a, alu_b}, 0);
        check_eq("mid_rst_result", rsp_result, 0);
        check_eq("mid_rst_ready_busy", {cmd_ready, busy}, 2'b10);
        clear_model();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || busy) stale++;
        end
        check_eq("no_stale_rsp", stale, 0);
        @(posedge clk);
        #1;
        send(4'b0101, 16'h00ff, 16'd4);
        wait_drain("drain_shl");
        check_eq("shl_result", last_rsp, 16'h0ff0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Sequencing stage directly upstream of the 16-bit ALU. It accepts ALU commands (opcode, operand A, operand B) over a valid/ready handshake and buffers them in a small FIFO. It drives the combinational ALU's aluop/valA/valB/sub inputs and holds them stable for a settle window. It then captures result and NZCV into a response register presented downstream over valid/ready. It also keeps a last-flags register and an illegal-opcode counter.

Parameters:
CMD_DEPTH, 2, command FIFO entries (power of 2, >=2)
SETTLE, 1, cycles ALU inputs are held before result/cc capture (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_op  in  4  ALU opcode
cmd_a  in  16  operand A
cmd_b  in  16  operand B
alu_op  out  4  to ALU aluop
alu_a  out  16  to ALU valA
alu_b  out  16  to ALU valB
alu_sub  out  1  to ALU sub
alu_result  in  16  from ALU result
alu_cc  in  4  from ALU cc (NZCV)
rsp_valid  out  1  response available
rsp_ready  in  1  downstream accepts
rsp_result  out  16  captured result
rsp_cc  out  4  captured NZCV
rsp_err  out  1  response is for an illegal opcode
last_cc  out  4  NZCV of most recent legal op
err_count  out  8  saturating count of illegal opcodes
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, FIFO empty.
  - All outputs 0: alu_op=0000, alu_a=alu_b=0, alu_sub=0, rsp_*=0, last_cc=0, err_count=0.
  - cmd_ready reads 1 once FIFO is empty (from reset onward).
  - Reset mid-operation discards the FIFO and any pending response.
- Legal opcodes: 0001 ADD, 0010 SUB, 0101 SHL, 0110 SHAR, 0111 SHLR, 1000 RL, 1001 RR, 1011 AND, 1100 OR, 1101 XOR, 1110 NOT, 1111 MUL.
- Illegal opcodes: 0000, 0011, 0100, 1010.
- Push: cmd_valid&cmd_ready writes {op,a,b} at tail. cmd_ready = !full only; no push-through when full even if a pop occurs that cycle.
- FSM states IDLE, DRIVE, RESP.
  - IDLE & FIFO non-empty: pop head at the edge.
    - Legal op: load alu_op/alu_a/alu_b. alu_sub=1 iff op==0010, else 0. Counter=SETTLE. Go to DRIVE.
    - Illegal op: alu_* unchanged, rsp_result=0, rsp_cc=0000, rsp_err=1, rsp_valid=1, err_count+1 (saturates at 255). Go to RESP.
  - DRIVE: counter decrements each cycle. At the edge ending the SETTLE-th DRIVE cycle:
    - rsp_result<=alu_result, rsp_cc<=alu_cc, rsp_err<=0, last_cc<=alu_cc, rsp_valid<=1.
    - Go to RESP.
  - RESP: hold rsp_* and alu_* stable while rsp_valid&!rsp_ready.
    - On rsp_ready: rsp_valid falls (unless reloaded below).
    - If FIFO non-empty, pop in the same edge with the IDLE pop rules (back-to-back). Otherwise go to IDLE.
- alu_* hold their last values in IDLE; they change only on a legal pop.
- Latency: empty FIFO, accept at edge E0 → pop at E1 → rsp_valid high after edge E1+SETTLE (SETTLE=1: 2 cycles after accept).
- Throughput: with rsp_ready tied 1, one legal response per SETTLE+1 cycles; one illegal response per cycle.
- Ordering: responses leave strictly in command order.
- FIFO: wrap-around pointers with an extra wrap bit; full/empty derived from them.
- Simultaneous push and pop when not full: both occur and the count is unchanged.

Test Plan:
- Reset then ADD A=10000 B=15000 with ALU model → alu_sub=0; rsp_result=25000; rsp_err=0; rsp_valid 2 cycles after accept (SETTLE=1); last_cc=rsp_cc.
- ADD 32767+1 then SUB 15000-5000 pushed back-to-back, rsp_ready=1 → responses 0x8000 (V,N set per ALU), then 10000 with alu_sub=1 during its DRIVE; order preserved; FIFO never overflows.
- Hold rsp_ready=0 and push 3 commands → cmd_ready drops after 2 FIFO entries plus 1 in RESP; rsp_result/alu_a/alu_b stay stable; releasing rsp_ready drains all 3 in order.
- Illegal op 1010 between two MULs (100*200, 54321*0) → middle response rsp_err=1, result 0, cc 0000; err_count=1; alu_op stays 1111; last_cc unchanged by the illegal op.
- 256 illegal ops → err_count saturates at 255.
- Assert rst_n low while in DRIVE with 2 queued → all outputs 0 immediately; no stale response after release; new SHL 0x00ff<<4 returns 0x0ff0.
